// File: rtl/collision_detect_pkg.sv
// Shared slot-bus layout, object type codes and scan FSM encodings for collision_detect.
// The dodge-score option is selected elsewhere with the COLLISION_SCORE_EN macro.
`ifndef CD_STATE_MACROS
`define CD_STATE_MACROS
`define cd_S_LATCH  2'd0
`define cd_S_SCAN   2'd1
`define cd_S_COMMIT 2'd2
`endif

package collision_detect_pkg;
    localparam int COORD_LEN = 8;
    localparam int TYPE_LEN  = 2;

    typedef logic [COORD_LEN-1:0] coord_t;

    // Packed LSB-first on the bus: type, x, y, width, height.
    typedef struct packed {
        coord_t              h;
        coord_t              w;
        coord_t              y;
        coord_t              x;
        logic [TYPE_LEN-1:0] kind;
    } slot_t;

    localparam int DATALEN   = $bits(slot_t);
    localparam int DATACOUNT = 5;

    localparam logic [TYPE_LEN-1:0] ENEMYTYPE  = 2'd1;
    localparam logic [TYPE_LEN-1:0] PLAYERTYPE = 2'd2;

    typedef enum logic [1:0] {
        S_LATCH  = `cd_S_LATCH,
        S_SCAN   = `cd_S_SCAN,
        S_COMMIT = `cd_S_COMMIT
    } state_t;
endpackage

// File: rtl/collision_detect_box_overlap.sv
// Combinational half-open box intersection test; sums are one bit wider than the
// coordinates so edges near the top of the field never wrap.
module box_overlap
    import collision_detect_pkg::*;
(
    input  logic [COORD_LEN-1:0] ax,
    input  logic [COORD_LEN-1:0] ay,
    input  logic [COORD_LEN-1:0] aw,
    input  logic [COORD_LEN-1:0] ah,
    input  logic [COORD_LEN-1:0] bx,
    input  logic [COORD_LEN-1:0] by,
    input  logic [COORD_LEN-1:0] bw,
    input  logic [COORD_LEN-1:0] bh,
    output logic                 overlap
);
    logic [COORD_LEN:0] a_right, a_bottom, b_right, b_bottom;
    logic               non_empty;

    always_comb begin
        a_right   = {1'b0, ax} + {1'b0, aw};
        a_bottom  = {1'b0, ay} + {1'b0, ah};
        b_right   = {1'b0, bx} + {1'b0, bw};
        b_bottom  = {1'b0, by} + {1'b0, bh};
        // A degenerate box would otherwise slip through when it sits strictly inside the other.
        non_empty = (aw != '0) && (ah != '0) && (bw != '0) && (bh != '0);
        overlap   = non_empty
                  && ({1'b0, bx} < a_right)  && ({1'b0, ax} < b_right)
                  && ({1'b0, by} < a_bottom) && ({1'b0, ay} < b_bottom);
    end
endmodule

// File: rtl/collision_detect.sv
// Scans the enemy slots of the gamedata bus one per clk3 against a latched player box,
// raising a sticky gameover; define COLLISION_SCORE_EN to enable the dodge score counter.
module collision_detect
    import collision_detect_pkg::*;
#(
    parameter int SLOTS  = DATACOUNT - 1,
    parameter int IDXW   = 4,
    parameter int SCOREW = 14
) (
    input  logic                         clk3,
    input  logic                         reset,
    input  logic                         pause,
    input  logic [DATALEN*(SLOTS+1)-1:0] gamedata,
    output logic                         gameover,
    output logic [IDXW-1:0]              hit_slot,
    output logic [SCOREW-1:0]            score,
    output logic                         pass_done
);
    slot_t slots [SLOTS+1];

    genvar gi;
    generate
        for (gi = 0; gi <= SLOTS; gi++) begin : g_slot
            assign slots[gi] = slot_t'(gamedata[gi*DATALEN +: DATALEN]);
        end
    endgenerate

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] first_hit_q, first_hit_d;
    logic [IDXW-1:0] hit_slot_q, hit_slot_d;
    logic            frame_hit_q, frame_hit_d;
    logic            gameover_q, gameover_d;
    logic            player_valid_q, player_valid_d;
    coord_t          px_q, py_q, pw_q, ph_q;
    coord_t          px_d, py_d, pw_d, ph_d;
    slot_t           cur_slot;
    logic            overlap_w;
    logic            hit_now;

    always_comb begin
        cur_slot = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (idx_q == IDXW'(i)) cur_slot = slots[i];
        end
    end

    box_overlap u_overlap (
        .ax(px_q), .ay(py_q), .aw(pw_q), .ah(ph_q),
        .bx(cur_slot.x), .by(cur_slot.y), .bw(cur_slot.w), .bh(cur_slot.h),
        .overlap(overlap_w)
    );

    assign hit_now = (cur_slot.kind == ENEMYTYPE) && player_valid_q && overlap_w;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        first_hit_d    = first_hit_q;
        hit_slot_d     = hit_slot_q;
        frame_hit_d    = frame_hit_q;
        gameover_d     = gameover_q;
        player_valid_d = player_valid_q;
        px_d = px_q;
        py_d = py_q;
        pw_d = pw_q;
        ph_d = ph_q;
        if (!pause) begin
            case (state_q)
                S_LATCH: begin
                    px_d           = slots[SLOTS].x;
                    py_d           = slots[SLOTS].y;
                    pw_d           = slots[SLOTS].w;
                    ph_d           = slots[SLOTS].h;
                    player_valid_d = (slots[SLOTS].kind == PLAYERTYPE);
                    idx_d          = '0;
                    state_d        = S_SCAN;
                end
                S_SCAN: begin
                    if (hit_now && !frame_hit_q) begin
                        frame_hit_d = 1'b1;
                        first_hit_d = idx_q;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDXW'(SLOTS - 1)) state_d = S_COMMIT;
                end
                S_COMMIT: begin
                    if (frame_hit_q && !gameover_q) begin
                        gameover_d = 1'b1;
                        hit_slot_d = first_hit_q;
                    end
                    frame_hit_d = 1'b0;
                    state_d     = S_LATCH;
                end
                default: state_d = S_LATCH;
            endcase
        end
    end

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            state_q        <= S_LATCH;
            idx_q          <= '0;
            first_hit_q    <= '0;
            hit_slot_q     <= '0;
            frame_hit_q    <= 1'b0;
            gameover_q     <= 1'b0;
            player_valid_q <= 1'b0;
            px_q <= '0;
            py_q <= '0;
            pw_q <= '0;
            ph_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            first_hit_q    <= first_hit_d;
            hit_slot_q     <= hit_slot_d;
            frame_hit_q    <= frame_hit_d;
            gameover_q     <= gameover_d;
            player_valid_q <= player_valid_d;
            px_q <= px_d;
            py_q <= py_d;
            pw_q <= pw_d;
            ph_q <= ph_d;
        end
    end

    assign gameover  = gameover_q;
    assign hit_slot  = hit_slot_q;
    assign pass_done = (state_q == S_COMMIT) && !pause;

`ifdef COLLISION_SCORE_EN
    logic [SLOTS-1:0]   passed_q, passed_d;
    logic [SCOREW-1:0]  score_q, score_d;
    logic [COORD_LEN:0] cur_right;

    always_comb begin
        passed_d  = passed_q;
        score_d   = score_q;
        cur_right = {1'b0, cur_slot.x} + {1'b0, cur_slot.w};
        if (!pause && state_q == S_SCAN) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (idx_q == IDXW'(i)) begin
                    // A slot that is gone or back ahead of the player must be dodged again to score.
                    if (cur_slot.kind != ENEMYTYPE || cur_right > {1'b0, px_q}) begin
                        passed_d[i] = 1'b0;
                    end else if (!passed_q[i] && !hit_now) begin
                        passed_d[i] = 1'b1;
                        if (!gameover_q && score_q != '1) score_d = score_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            passed_q <= '0;
            score_q  <= '0;
        end else begin
            passed_q <= passed_d;
            score_q  <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif
endmodule
